// File: rtl/perf_pkg.sv
// Shared types for the performance counter controller: command, read-select and FSM encodings.
package perf_pkg;

   typedef enum logic [1:0] {
      CMD_START = 2'b00,
      CMD_STOP  = 2'b01,
      CMD_CLEAR = 2'b10,
      CMD_SNAP  = 2'b11
   } perf_cmd_e;

   typedef enum logic [1:0] {
      SEL_CYCLE   = 2'b00,
      SEL_INSN    = 2'b01,
      SEL_CTRL    = 2'b10,
      SEL_MISPRED = 2'b11
   } perf_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_SNAP = 2'b10
   } perf_state_e;

   localparam int unsigned NUM_CNT = 4;

endpackage

// File: rtl/perf_counter.sv
// One event counter with a sticky overflow flag; wraps or saturates at all-ones.
module perf_counter #(
   parameter int unsigned CNT_W    = 32,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt_nxt,
   output logic             o_ovf
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_ovf;
   logic             w_ovf_nxt;

   // Clear wins over increment so events in the clear cycle are dropped.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_ovf_nxt = r_ovf;
      if (i_clr) begin
         w_cnt_nxt = '0;
         w_ovf_nxt = 1'b0;
      end else if (i_inc) begin
         if (&r_cnt) begin
            w_ovf_nxt = 1'b1;
            w_cnt_nxt = SATURATE ? r_cnt : '0;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_ovf <= w_ovf_nxt;
      end
   end

   assign o_cnt_nxt = w_cnt_nxt;
   assign o_ovf     = r_ovf;

endmodule

// File: rtl/perf_counter_ctrl.sv
// Run-control FSM, event qualification, snapshot shadows and read port for the
// pipeline performance counters.
module perf_counter_ctrl
   import perf_pkg::*;
#(
   parameter int unsigned CNT_W    = 32,
   parameter bit          SATURATE = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_insn_vld,
   input  logic               i_ctrl,
   input  logic               i_mispred,
   input  logic               i_cmd_vld,
   input  logic [1:0]         i_cmd,
   output logic               o_cmd_rdy,
   input  logic               i_rd_vld,
   input  logic [1:0]         i_rd_sel,
   output logic               o_rd_vld,
   output logic [CNT_W-1:0]   o_rd_data,
   output logic               o_running,
   output logic [NUM_CNT-1:0] o_ovf
);

   perf_state_e r_state;
   perf_state_e w_state_nxt;
   logic        r_snap_from_run;
   logic        w_snap_from_run_nxt;
   perf_cmd_e   w_cmd;
   logic        w_cmd_acc;
   logic        w_clr;
   logic        w_count_en;

   logic [NUM_CNT-1:0]            w_inc;
   logic [NUM_CNT-1:0][CNT_W-1:0] w_cnt_nxt;
   logic [NUM_CNT-1:0][CNT_W-1:0] r_shadow;
   logic                          r_rd_vld;
   logic [CNT_W-1:0]              r_rd_data;

   assign w_cmd     = perf_cmd_e'(i_cmd);
   assign o_cmd_rdy = (r_state != ST_SNAP);
   assign w_cmd_acc = i_cmd_vld & o_cmd_rdy;
   assign w_clr     = w_cmd_acc & (w_cmd == CMD_CLEAR);

   always_comb begin
      w_state_nxt         = r_state;
      w_snap_from_run_nxt = r_snap_from_run;
      unique case (r_state)
         ST_IDLE: begin
            if (w_cmd_acc) begin
               case (w_cmd)
                  CMD_START: w_state_nxt = ST_RUN;
                  CMD_SNAP: begin
                     w_state_nxt         = ST_SNAP;
                     w_snap_from_run_nxt = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            if (w_cmd_acc) begin
               case (w_cmd)
                  CMD_STOP: w_state_nxt = ST_IDLE;
                  CMD_SNAP: begin
                     w_state_nxt         = ST_SNAP;
                     w_snap_from_run_nxt = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_SNAP: w_state_nxt = r_snap_from_run ? ST_RUN : ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state         <= ST_IDLE;
         r_snap_from_run <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_snap_from_run <= w_snap_from_run_nxt;
      end
   end

   assign w_count_en = (r_state == ST_RUN) | ((r_state == ST_SNAP) & r_snap_from_run);
   assign o_running  = w_count_en;

   // Mispredict and ctrl strobes only count when qualified by a retiring instruction.
   assign w_inc[0] = w_count_en;
   assign w_inc[1] = w_count_en & i_insn_vld;
   assign w_inc[2] = w_count_en & i_insn_vld & i_ctrl;
   assign w_inc[3] = w_count_en & i_insn_vld & i_ctrl & i_mispred;

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      perf_counter #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_cnt (
         .i_clk     (i_clk),
         .i_reset   (i_reset),
         .i_inc     (w_inc[g]),
         .i_clr     (w_clr),
         .o_cnt_nxt (w_cnt_nxt[g]),
         .o_ovf     (o_ovf[g])
      );
   end

   // Shadows capture the post-increment values so the SNAP cycle itself is included.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_shadow  <= '0;
         r_rd_vld  <= 1'b0;
         r_rd_data <= '0;
      end else begin
         if (r_state == ST_SNAP) begin
            r_shadow <= w_cnt_nxt;
         end
         r_rd_vld <= i_rd_vld;
         if (i_rd_vld) begin
            r_rd_data <= r_shadow[i_rd_sel];
         end
      end
   end

   assign o_rd_vld  = r_rd_vld;
   assign o_rd_data = r_rd_data;

endmodule
